trace_collector: RTL
====================

// Module: trace_collector
// PURPOSE
//   Multi-source debug trace collector for the MPSoC. Replaces fixed-priority trace muxing
//   with NSRC per-source queues, a round-robin drain and a circular capture buffer.
//   Every buffered entry is tagged {source id, timestamp, data}. Sources are the tiles and the NoC.
//   The buffer supports a wrap mode and a stop-when-full mode, per-source drop counters and a
//   show-ahead read port for the JTAG debug path.
// PARAMETERS
//   NSRC           5    number of trace sources (>=2)
//   Fpay           32   trace data width per source
//   SRC_FIFO_DEPTH 4    per-source queue depth (power of 2, >=2)
//   TB_DEPTH       512  capture buffer entries (power of 2, >=4)
//   TSw            16   timestamp width
//   DROPw          8    per-source drop counter width
//   (derived) SRCw=log2(NSRC), Ew=SRCw+TSw+Fpay, CNTw=log2(TB_DEPTH)+1
// PORTS
//   clk          in   1           clock
//   reset        in   1           synchronous, active-high reset
//   trigger_all  in   NSRC        per-source trace strobe; bit i qualifies trace_all slice i
//   trace_all    in   NSRC*Fpay   per-source trace data; slice i is [(i+1)*Fpay-1 : i*Fpay]
//   capture_en   in   1           1: accept triggers; 0: ignore new triggers
//   mode_wrap    in   1           1: overwrite the oldest entry when full; 0: stop capture when full
//   rd           in   1           pop the oldest buffer entry
//   dout         out  Ew          oldest entry {src_id, timestamp, data} (show-ahead)
//   dout_valid   out  1           buffer non-empty
//   count        out  CNTw        number of valid entries in the buffer
//   full         out  1           count == TB_DEPTH
//   drop_any     out  1           sticky: at least one trigger has been dropped since reset
//   drop_cnt_all out  NSRC*DROPw  per-source saturating drop counters
// BEHAVIOUR
//   Reset
//   - Clears timestamp, all queue/buffer pointers, count, drop counters, drop_any and the
//     arbiter pointer (points at source 0).
//   - Outputs after reset: dout_valid=0, count=0, full=0, drop_any=0, drop_cnt_all=0;
//     dout don't-care while dout_valid=0.
//   - Reset asserted mid-operation discards all queued and buffered entries in the same edge.
//   Timestamp
//   - Free-running TSw counter, +1 per cycle, wraps to 0.
//   - The value sampled at the trigger edge is stored with the entry.
//   Source queue i
//   - On an edge with trigger_all[i]=1 and capture_en=1, push {ts, trace slice i}.
//   - If queue i is full at that edge, the entry is dropped: drop_cnt[i] +1 (saturating at
//     all-ones) and drop_any<=1.
//   - A push and a pop of the same queue in the same cycle are both allowed when the queue is full.
//   - Triggers with capture_en=0 are ignored and not counted as drops.
//   - Queued entries keep draining regardless of capture_en.
//   Arbiter
//   - Each cycle grants one non-empty queue, round-robin starting at the pointer.
//   - After a grant to g, the pointer becomes (g+1) mod NSRC.
//   - No grant when all queues are empty.
//   - No grant when full=1 and mode_wrap=0, unless rd pops in the same cycle.
//   Buffer write
//   - The granted entry is written at wr_ptr with src_id=g; wr_ptr wraps modulo TB_DEPTH.
//   - Full with mode_wrap=1 and no rd: the oldest entry is overwritten, rd_ptr advances,
//     count stays TB_DEPTH.
//   - Full with rd and a write in the same cycle: pop plus write, count unchanged, no overwrite.
//   - mode_wrap changes take effect on the next edge.
//   Read
//   - dout = mem[rd_ptr], driven combinationally from the registered rd_ptr.
//   - rd=1 with dout_valid=1 advances rd_ptr and decrements count.
//   - rd with dout_valid=0 is ignored.
//   Latency
//   - Trigger sampled at edge k -> queued at k -> granted in cycle k+1 -> written at edge k+1.
//   - With an empty system, dout_valid=1 and the entry is on dout after edge k+1
//     (2-cycle trigger-to-visible).
//   Count
//   - count = writes - reads (net), never exceeds TB_DEPTH; full and dout_valid are derived
//     from count.
// TESTING
//   1 Empty system, ts=5 at edge k, trigger_all=5'b00100, slice2=32'hDEADBEEF
//     -> after edge k+1: dout_valid=1, dout={3'd2,16'd5,32'hDEADBEEF}, count=1.
//   2 All 5 sources trigger in one cycle with arbiter ptr=0
//     -> entries appear in src order 0,1,2,3,4 over 5 cycles, no drops.
//     A second burst with ptr at 0 repeats the order.
//   3 TB_DEPTH=8, buffer full, mode_wrap=0, src1 triggers 10 consecutive cycles
//     -> queue1 holds 4, drop_cnt[1]=6, drop_any=1, count stays 8, buffer contents unchanged.
//   4 TB_DEPTH=8, mode_wrap=1, write entries E0..E9 from src0
//     -> count=8, full=1, dout=E2; 8 reads return E2..E9, then dout_valid=0.
//   5 rd on empty -> no state change. Full+wrap, rd and write in the same cycle
//     -> count=8, dout shows the next oldest entry.
//     drop_cnt at 255 plus another drop -> stays 255.
//   6 Assert reset for 1 cycle with 3 entries buffered and 2 queued
//     -> next cycle count=0, dout_valid=0, drop counters 0, timestamp 0.

Source files
------------

// File: rtl/trace_collector.sv
// -----------------------------------------------------------------------------
// trace_collector
//   Multi-source debug trace collector. Each of NSRC sources has a small FIFO
//   that captures {timestamp, data} on its trigger strobe. A round-robin
//   arbiter drains one non-empty FIFO per cycle into a circular capture buffer.
//   Each buffered entry is tagged {src_id, timestamp, data}. The buffer either
//   overwrites its oldest entry when full (mode_wrap=1) or stops accepting
//   entries (mode_wrap=0). A trigger that finds its FIFO full is dropped and
//   counted in a per-source saturating counter. The read port is show-ahead.
//
// Ports
//   clk          clock
//   reset        synchronous active-high reset
//   trigger_all  per-source trace strobe (bit i qualifies slice i of trace_all)
//   trace_all    per-source trace data, slice i = [(i+1)*Fpay-1 : i*Fpay]
//   capture_en   1: accept triggers, 0: ignore new triggers
//   mode_wrap    1: overwrite oldest entry when full, 0: stop capture when full
//   rd           pop the oldest buffer entry (ignored when empty)
//   dout         oldest entry {src_id, timestamp, data}, valid with dout_valid
//   dout_valid   buffer non-empty
//   count        number of valid buffer entries
//   full         count == TB_DEPTH
//   drop_any     sticky flag: some trigger was dropped since reset
//   drop_cnt_all per-source saturating drop counters, packed like trace_all
// -----------------------------------------------------------------------------
module trace_collector #(
  parameter int NSRC           = 5,
  parameter int Fpay           = 32,
  parameter int SRC_FIFO_DEPTH = 4,
  parameter int TB_DEPTH       = 512,
  parameter int TSw            = 16,
  parameter int DROPw          = 8,
  localparam int SRCw          = $clog2(NSRC),
  localparam int Ew            = SRCw + TSw + Fpay,
  localparam int CNTw          = $clog2(TB_DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NSRC-1:0]        trigger_all,
  input  logic [NSRC*Fpay-1:0]   trace_all,
  input  logic                   capture_en,
  input  logic                   mode_wrap,
  input  logic                   rd,
  output logic [Ew-1:0]          dout,
  output logic                   dout_valid,
  output logic [CNTw-1:0]        count,
  output logic                   full,
  output logic                   drop_any,
  output logic [NSRC*DROPw-1:0]  drop_cnt_all
);

  localparam int QAw = $clog2(SRC_FIFO_DEPTH);
  localparam int TAw = $clog2(TB_DEPTH);
  localparam int QW  = TSw + Fpay;

  localparam logic [QAw:0]      Q_FULL   = (QAw+1)'(SRC_FIFO_DEPTH);
  localparam logic [CNTw-1:0]   TB_FULL  = CNTw'(TB_DEPTH);
  localparam logic [SRCw-1:0]   SRC_LAST = SRCw'(NSRC - 1);

  // Free-running timestamp; the pre-edge value is captured with each trigger.
  logic [TSw-1:0]             ts_reg;

  logic [NSRC-1:0]            q_nonempty;
  logic [NSRC-1:0]            q_full;
  logic [NSRC-1:0]            q_pop;
  logic [NSRC-1:0]            q_drop;
  logic [NSRC-1:0][QW-1:0]    q_head;

  logic [SRCw-1:0]            arb_ptr_reg;
  logic [SRCw-1:0]            grant_idx;
  logic                       grant_valid;

  logic [TAw-1:0]             wr_ptr_reg;
  logic [TAw-1:0]             rd_ptr_reg;
  logic [CNTw-1:0]            count_reg;
  logic                       drop_any_reg;
  logic                       buf_full;
  logic                       do_rd;
  logic                       overwrite;

  logic [Ew-1:0]              tb_mem [TB_DEPTH];

  // ---------------------------------------------------------------------------
  // Per-source queues
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
    localparam logic [SRCw-1:0] SRC_ID = SRCw'(gi);

    logic [QW-1:0]    q_mem [SRC_FIFO_DEPTH];
    logic [QAw-1:0]   q_wr_ptr_reg;
    logic [QAw-1:0]   q_rd_ptr_reg;
    logic [QAw:0]     q_cnt_reg;
    logic [DROPw-1:0] drop_cnt_reg;
    logic             trig;
    logic             push;

    assign trig           = capture_en & trigger_all[gi];
    assign q_nonempty[gi] = (q_cnt_reg != '0);
    assign q_full[gi]     = (q_cnt_reg == Q_FULL);
    assign q_pop[gi]      = grant_valid & (grant_idx == SRC_ID);
    // A full queue still accepts a push when its head leaves in the same cycle.
    assign push           = trig & (~q_full[gi] | q_pop[gi]);
    assign q_drop[gi]     = trig & q_full[gi] & ~q_pop[gi];
    assign q_head[gi]     = q_mem[q_rd_ptr_reg];
    assign drop_cnt_all[gi*DROPw +: DROPw] = drop_cnt_reg;

    always_ff @(posedge clk) begin
      if (reset) begin
        q_wr_ptr_reg <= '0;
        q_rd_ptr_reg <= '0;
        q_cnt_reg    <= '0;
        drop_cnt_reg <= '0;
      end else begin
        if (push)
          q_wr_ptr_reg <= q_wr_ptr_reg + QAw'(1);
        if (q_pop[gi])
          q_rd_ptr_reg <= q_rd_ptr_reg + QAw'(1);
        if (push && !q_pop[gi])
          q_cnt_reg <= q_cnt_reg + (QAw+1)'(1);
        else if (!push && q_pop[gi])
          q_cnt_reg <= q_cnt_reg - (QAw+1)'(1);
        if (q_drop[gi] && (drop_cnt_reg != '1))
          drop_cnt_reg <= drop_cnt_reg + DROPw'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (push)
        q_mem[q_wr_ptr_reg] <= {ts_reg, trace_all[gi*Fpay +: Fpay]};
    end
  end

  // ---------------------------------------------------------------------------
  // Round-robin arbiter: first non-empty queue at or after arb_ptr_reg.
  // Held off when the buffer is full in stop mode and nothing is being read.
  // ---------------------------------------------------------------------------
  always_comb begin
    int              idx;
    logic [SRCw-1:0] idx_s;
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    idx_s       = '0;
    if (!(buf_full && !mode_wrap && !rd)) begin
      for (int off = 0; off < NSRC; off++) begin
        idx = int'(arb_ptr_reg) + off;
        if (idx >= NSRC)
          idx = idx - NSRC;
        idx_s = idx[SRCw-1:0];
        if (!grant_valid && q_nonempty[idx_s]) begin
          grant_valid = 1'b1;
          grant_idx   = idx_s;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Capture buffer
  // ---------------------------------------------------------------------------
  assign buf_full  = (count_reg == TB_FULL);
  assign do_rd     = rd & (count_reg != '0);
  // Only reachable with mode_wrap=1: the arbiter blocks a full write otherwise.
  assign overwrite = grant_valid & buf_full & ~do_rd;

  always_ff @(posedge clk) begin
    if (reset) begin
      ts_reg       <= '0;
      arb_ptr_reg  <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      drop_any_reg <= 1'b0;
    end else begin
      ts_reg <= ts_reg + TSw'(1);
      if (grant_valid) begin
        wr_ptr_reg  <= wr_ptr_reg + TAw'(1);
        arb_ptr_reg <= (grant_idx == SRC_LAST) ? '0 : grant_idx + SRCw'(1);
      end
      if (do_rd || overwrite)
        rd_ptr_reg <= rd_ptr_reg + TAw'(1);
      // Overwrite and write-with-read both leave the count unchanged.
      if (grant_valid && !overwrite && !do_rd)
        count_reg <= count_reg + CNTw'(1);
      else if (!grant_valid && do_rd)
        count_reg <= count_reg - CNTw'(1);
      if (|q_drop)
        drop_any_reg <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (grant_valid)
      tb_mem[wr_ptr_reg] <= {grant_idx, q_head[grant_idx]};
  end

  assign dout       = tb_mem[rd_ptr_reg];
  assign dout_valid = (count_reg != '0);
  assign count      = count_reg;
  assign full       = buf_full;
  assign drop_any   = drop_any_reg;

endmodule
